// File: rtl/sdram_pkg.sv
// Shared widths and state encoding for the SDRAM burst master.
package sdram_pkg;

   localparam int unsigned SDRAM_ADDR_W = 22;
   localparam int unsigned SDRAM_XY_W   = 11;
   localparam int unsigned SDRAM_DATA_W = 16;
   localparam int unsigned BURST_LEN_W  = 9;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      REQ     = 2'd2,
      RELEASE = 2'd3
   } state_t;

endpackage

// File: rtl/sdram_burst_master.sv
// Burst master: walks a run of consecutive word addresses, issuing one
// 4-phase command/response handshake to the SDRAM controller per word.
module sdram_burst_master
   import sdram_pkg::*;
(
   input  logic                    osc_50,
   input  logic                    reset_50m,
   input  logic                    start,
   input  logic                    write,
   input  logic [SDRAM_ADDR_W-1:0] start_addr,
   input  logic [BURST_LEN_W-1:0]  length,
   input  logic [SDRAM_DATA_W-1:0] wr_data,
   output logic                    wr_next,
   output logic [SDRAM_DATA_W-1:0] rd_data,
   output logic                    rd_valid,
   output logic                    busy,
   output logic                    done,
   output logic                    sdram_command,
   input  logic                    sdram_response,
   output logic                    sdram_write,
   output logic [SDRAM_XY_W-1:0]   sdram_x,
   output logic [SDRAM_XY_W-1:0]   sdram_y,
   output logic [SDRAM_DATA_W-1:0] sdram_data_write,
   input  logic [SDRAM_DATA_W-1:0] sdram_data_read
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [BURST_LEN_W-1:0]  r_remaining;
   logic [SDRAM_ADDR_W-1:0] r_addr;
   logic                    r_dir;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_rd_valid;
   logic                    r_wr_next;
   logic [SDRAM_DATA_W-1:0] r_rd_data;
   logic [SDRAM_DATA_W-1:0] r_data_write;

   logic                    w_load;
   logic                    w_zero_len;
   logic                    w_enter_req;
   logic                    w_capture;
   logic                    w_finish;

   // State register
   always_ff @(posedge osc_50 or posedge reset_50m) begin
      if (reset_50m) r_state <= IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next-state and datapath strobes
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_zero_len  = 1'b0;
      w_enter_req = 1'b0;
      w_capture   = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (length != '0) begin
                  w_load      = 1'b1;
                  w_state_nxt = SETTLE;
               end else begin
                  w_zero_len  = 1'b1;
               end
            end
         end
         // Wait out any response still high from an earlier transaction
         SETTLE: begin
            if (!sdram_response) begin
               w_enter_req = 1'b1;
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            if (sdram_response) begin
               w_capture   = 1'b1;
               w_state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            if (!sdram_response) begin
               if (r_remaining != '0) begin
                  w_enter_req = 1'b1;
                  w_state_nxt = REQ;
               end else begin
                  w_finish    = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Burst registers and registered strobes
   always_ff @(posedge osc_50 or posedge reset_50m) begin
      if (reset_50m) begin
         r_remaining  <= '0;
         r_addr       <= '0;
         r_dir        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_rd_valid   <= 1'b0;
         r_wr_next    <= 1'b0;
         r_rd_data    <= '0;
         r_data_write <= '0;
      end else begin
         r_done     <= w_zero_len | w_finish;
         r_wr_next  <= w_enter_req;
         r_rd_valid <= w_capture & ~r_dir;
         if (w_load) begin
            r_remaining <= length;
            r_addr      <= start_addr;
            r_dir       <= write;
            r_busy      <= 1'b1;
         end
         if (w_finish) r_busy <= 1'b0;
         if (w_enter_req) r_data_write <= wr_data;
         if (w_capture) begin
            if (!r_dir) r_rd_data <= sdram_data_read;
            r_remaining <= r_remaining - BURST_LEN_W'(1);
            r_addr      <= r_addr + SDRAM_ADDR_W'(1);
         end
      end
   end

   // Command comes straight off the state register so it cannot glitch
   assign sdram_command    = (r_state == REQ);
   assign sdram_write      = r_dir;
   assign sdram_y          = r_addr[SDRAM_ADDR_W-1:SDRAM_XY_W];
   assign sdram_x          = r_addr[SDRAM_XY_W-1:0];
   assign sdram_data_write = r_data_write;
   assign rd_data          = r_rd_data;
   assign rd_valid         = r_rd_valid;
   assign busy             = r_busy;
   assign done             = r_done;
   assign wr_next          = r_wr_next;

endmodule
